// File: rtl/u_ofdm_demap.sv
// U-OFDM receive demapper: rebuilds bipolar samples as pos[k]-neg[k]
// and streams them to the FFT sink; frame counter under UOFDM_DEMAP_FRAME_CNT_EN.
module u_ofdm_demap #(
    parameter int DW = 8,
    parameter int N  = 128,
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] data_in,
    input  logic          in_valid,
    input  logic          in_sop,
    input  logic          sink_ready,
    output logic [DW:0]   sink_real,
    output logic [DW:0]   sink_imag,
    output logic          sink_valid,
    output logic          sink_sop,
    output logic          sink_eop,
    output logic          frame_drop,
    output logic          busy,
    output logic [15:0]   frame_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        FILL_POS,
        FILL_NEG,
        DRAIN
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(N - 1);

    state_t        state;
    logic [DW:0]   mem [N];
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] rd_nxt;
    logic          start;
    logic          xfer;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW:0]   wr_data;

    assign start     = in_valid && in_sop;
    assign xfer      = sink_valid && sink_ready;
    assign rd_nxt    = rd_idx + AW'(1);
    assign busy      = (state != IDLE);
    assign sink_imag = '0;

    // Write port: positive half stores zero-extended, negative half
    // reads the stored positive sample and writes back the difference.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = wr_idx;
        wr_data = {1'b0, data_in};
        case (state)
            IDLE: begin
                if (start) begin
                    wr_en   = 1'b1;
                    wr_addr = '0;
                end
            end
            FILL_POS: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (in_sop) wr_addr = '0;
                end
            end
            FILL_NEG: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (in_sop) wr_addr = '0;
                    else wr_data = mem[wr_idx] - {1'b0, data_in};
                end
            end
            default: ;
        endcase
    end

    // Sample storage, no reset needed: contents are always rewritten
    // before they are read out.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Frame FSM with registered sink outputs and drop pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wr_idx     <= '0;
            rd_idx     <= '0;
            sink_real  <= '0;
            sink_valid <= 1'b0;
            sink_sop   <= 1'b0;
            sink_eop   <= 1'b0;
            frame_drop <= 1'b0;
        end else begin
            frame_drop <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        wr_idx <= AW'(1);
                        state  <= FILL_POS;
                    end
                end
                FILL_POS: begin
                    if (in_valid) begin
                        if (in_sop) begin
                            frame_drop <= 1'b1;
                            wr_idx     <= AW'(1);
                        end else if (wr_idx == LAST) begin
                            wr_idx <= '0;
                            state  <= FILL_NEG;
                        end else begin
                            wr_idx <= wr_idx + AW'(1);
                        end
                    end
                end
                FILL_NEG: begin
                    if (in_valid) begin
                        if (in_sop) begin
                            frame_drop <= 1'b1;
                            wr_idx     <= AW'(1);
                            state      <= FILL_POS;
                        end else if (wr_idx == LAST) begin
                            wr_idx     <= '0;
                            rd_idx     <= '0;
                            sink_real  <= mem[0];
                            sink_valid <= 1'b1;
                            sink_sop   <= 1'b1;
                            sink_eop   <= (LAST == '0);
                            state      <= DRAIN;
                        end else begin
                            wr_idx <= wr_idx + AW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (start) frame_drop <= 1'b1;
                    if (xfer) begin
                        if (sink_eop) begin
                            sink_valid <= 1'b0;
                            sink_sop   <= 1'b0;
                            sink_eop   <= 1'b0;
                            sink_real  <= '0;
                            state      <= IDLE;
                        end else begin
                            rd_idx    <= rd_nxt;
                            sink_real <= mem[rd_nxt];
                            sink_sop  <= 1'b0;
                            sink_eop  <= (rd_nxt == LAST);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UOFDM_DEMAP_FRAME_CNT_EN
    // Completed-frame counter, advances on each eop transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) frame_cnt <= '0;
        else if (xfer && sink_eop) frame_cnt <= frame_cnt + 16'd1;
    end
`else
    assign frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_u_ofdm_demap.sv
// Scoreboard bench for u_ofdm_demap: stimulus pushes expected pos-neg
// values, a monitor pops and compares on every sink transfer.
module tb_u_ofdm_demap;

    localparam int DW = 8;
    localparam int N  = 128;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          in_valid = 1'b0;
    logic          in_sop = 1'b0;
    logic          sink_ready = 1'b1;
    logic [DW:0]   sink_real;
    logic [DW:0]   sink_imag;
    logic          sink_valid;
    logic          sink_sop;
    logic          sink_eop;
    logic          frame_drop;
    logic          busy;
    logic [15:0]   frame_cnt;

    u_ofdm_demap #(.DW(DW), .N(N), .AW(AW)) dut (
        .clk(clk), .reset(reset), .data_in(data_in),
        .in_valid(in_valid), .in_sop(in_sop),
        .sink_ready(sink_ready), .sink_real(sink_real),
        .sink_imag(sink_imag), .sink_valid(sink_valid),
        .sink_sop(sink_sop), .sink_eop(sink_eop),
        .frame_drop(frame_drop), .busy(busy),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int drops = 0;
    int frames_done = 0;
    int rmode = 0;
    int vcyc = 0;
    int last_drain = 0;
    bit first_rdy = 0;
    bit last_first = 0;
    bit prev_valid = 0;

    // expected {real, sop, eop}
    logic [DW+2:0] exp_q[$];

    int pos_a[N];
    int neg_a[N];

    task automatic chk(input string nm, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    // ready pattern generator
    always begin
        @(posedge clk);
        #1;
        case (rmode)
            0: sink_ready = 1'b1;
            1: sink_ready = ~sink_ready;
            default: sink_ready = 1'b0;
        endcase
    end

    // monitor / scoreboard
    bit            hold_pend = 0;
    logic [DW+2:0] held;
    always @(negedge clk) begin
        if (!reset) begin
            hold_pend = 0;
            prev_valid = 0;
            frames_done = 0;
        end else begin
            if (frame_drop) drops++;
            if (!sink_valid && (sink_sop || sink_eop))
                chk("sop_eop_without_valid", 1, 0);
            if (hold_pend)
                chk("hold_stable", {sink_valid, sink_real, sink_sop, sink_eop},
                    {1'b1, held});
            if (sink_valid && !prev_valid) begin
                vcyc = 0;
                first_rdy = sink_ready;
            end
            if (sink_valid) vcyc++;
            if (sink_valid && sink_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    logic [DW+2:0] e;
                    e = exp_q.pop_front();
                    chk("sink_out", {sink_real, sink_sop, sink_eop}, e);
                    chk("sink_imag", sink_imag, 0);
                end
                if (sink_eop) begin
                    frames_done++;
                    last_drain = vcyc;
                    last_first = first_rdy;
                end
            end
            hold_pend = sink_valid && !sink_ready;
            held = {sink_real, sink_sop, sink_eop};
            prev_valid = sink_valid;
        end
    end

    task automatic drive(input int d, input bit s);
        data_in  = d[DW-1:0];
        in_sop   = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    task automatic push_exp();
        for (int k = 0; k < N; k++) begin
            logic [DW:0] dv;
            dv = DW'(pos_a[k]) - DW'(0) == 0 ? '0 : '0;
            dv = 9'(pos_a[k] - neg_a[k]);
            exp_q.push_back({dv, k == 0, k == N - 1});
        end
    endtask

    // back-to-back 2N samples; checks first output latency
    task automatic send_frame();
        int c;
        push_exp();
        for (int k = 0; k < N; k++) begin
            data_in = pos_a[k][DW-1:0]; in_sop = (k == 0); in_valid = 1'b1;
            @(posedge clk); #1;
        end
        for (int k = 0; k < N; k++) begin
            data_in = neg_a[k][DW-1:0]; in_sop = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        c = 0;
        while (!sink_valid && c < 2) begin
            @(posedge clk); #1; c++;
        end
        if (rmode != 2 || c > 0) chk("first_valid_latency", sink_valid, 1);
        else chk("first_valid_latency", sink_valid, 1);
    endtask

    task automatic wait_idle();
        int c = 0;
        while (busy && c < 1000) begin
            @(posedge clk); #1; c++;
        end
        chk("busy_falls", busy, 0);
        @(negedge clk);
        @(posedge clk); #1;
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic fill_rand();
        for (int k = 0; k < N; k++) begin
            pos_a[k] = $urandom_range(0, 255);
            neg_a[k] = $urandom_range(0, 255);
        end
    endtask

    task automatic chk_reset_outs();
        chk("rst_valid", sink_valid, 0);
        chk("rst_real", sink_real, 0);
        chk("rst_sop_eop", {sink_sop, sink_eop}, 0);
        chk("rst_drop", frame_drop, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
    endtask

    int exp_drops;

    initial begin
        exp_drops = 0;
        #3;
        chk_reset_outs();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // stray samples without sop are ignored
        for (int i = 0; i < 4; i++) drive(i + 7, 1'b0);
        chk("idle_ignore", busy, 0);

        // basic frame
        for (int k = 0; k < N; k++) begin
            pos_a[k] = k + 100; neg_a[k] = k;
        end
        send_frame();
        wait_idle();

        // extremes mixed by index
        for (int k = 0; k < N; k++) begin
            case (k % 3)
                0: begin pos_a[k] = 255; neg_a[k] = 0; end
                1: begin pos_a[k] = 0; neg_a[k] = 255; end
                default: begin pos_a[k] = 37; neg_a[k] = 37; end
            endcase
        end
        send_frame();
        wait_idle();

        // random frame
        fill_rand();
        send_frame();
        wait_idle();

        // backpressure: alternating ready
        rmode = 1;
        fill_rand();
        send_frame();
        wait_idle();
        chk("drain_cycles", last_drain, last_first ? 2 * N - 1 : 2 * N);
        rmode = 0;

        // resync at positive sample 50
        for (int k = 0; k < 50; k++) drive(k + 3, k == 0);
        for (int k = 0; k < N; k++) begin
            pos_a[k] = 200; neg_a[k] = 50;
        end
        exp_drops = drops + 1;
        send_frame();
        chk("resync_drop", drops, exp_drops);
        wait_idle();

        // new frame arriving during drain
        rmode = 2;
        fill_rand();
        send_frame();
        exp_drops = drops + 1;
        for (int k = 0; k < 20; k++) drive($urandom_range(0, 255), k == 0);
        repeat (3) @(posedge clk);
        #1;
        chk("drain_drop", drops, exp_drops);
        chk("drain_busy", busy, 1);
        rmode = 0;
        wait_idle();
        chk("drain_no_extra_drop", drops, exp_drops);

        // async reset during negative half, sample 60
        fill_rand();
        for (int k = 0; k < N; k++) drive(pos_a[k], k == 0);
        for (int k = 0; k < 60; k++) drive(neg_a[k], 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_outs();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_cnt", frame_cnt, 0);

        // three clean frames after reset
        for (int f = 0; f < 3; f++) begin
            fill_rand();
            send_frame();
            wait_idle();
        end
`ifdef UOFDM_DEMAP_FRAME_CNT_EN
        chk("frame_cnt", frame_cnt, frames_done);
        chk("frame_cnt_three", frame_cnt, 3);
`else
        chk("frame_cnt_off", frame_cnt, 0);
`endif
        chk("frames_seen", frames_done, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // hard time limit
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/u_ofdm_demap.md
Name: u_ofdm_demap

Overview:
- Receive-side counterpart of the U-OFDM mapper. Consumes one CP-stripped U-OFDM frame of 2*N unipolar ADC samples: N positive-half samples, then N negative-half samples.
- Rebuilds the N bipolar time samples as pos[k] - neg[k] and streams them to the 128-point FFT core using the FFT sink handshake (sink_valid/sink_ready/sink_sop/sink_eop).
- Sits between CP removal and the FFT IP, ahead of 16QAM demapping.

Parameters:
- DW, 8, input sample width (unsigned).
- N, 128, FFT points = samples per U-OFDM half-frame.
- AW, 7, index width, log2(N).

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  DW  unipolar sample, unsigned.
- in_valid  input  1  data_in valid this cycle.
- in_sop  input  1  qualifies the first sample of a 2*N frame; meaningful only with in_valid.
- sink_ready  input  1  FFT ready to accept a sample.
- sink_real  output  DW+1  reconstructed bipolar sample, two's complement.
- sink_imag  output  DW+1  constant 0.
- sink_valid  output  1  sink_real valid.
- sink_sop  output  1  marks output index 0.
- sink_eop  output  1  marks output index N-1.
- frame_drop  output  1  one-cycle pulse when a frame is aborted or rejected.
- busy  output  1  high when state != IDLE.
- frame_cnt  output  16  count of completed frames (see Optional Feature).

Behaviour:
- Reset (async, active-low): state=IDLE; index counters=0; all outputs 0. Reset mid-frame aborts the frame; no partial output follows.
- Storage: N x (DW+1) array. Each positive sample is written zero-extended. Each negative sample overwrites the same location with the difference.
- Back-to-back in_valid (one sample per clk) is supported in every fill state. An internal read-modify-write pipeline is allowed, provided the added latency is at most 1 clk.
- IDLE:
  - in_valid&&in_sop: store sample at index 0, set wr_idx=1, go to FILL_POS.
  - in_valid without in_sop: ignored.
- FILL_POS:
  - Each in_valid stores at wr_idx and increments it.
  - After index N-1 is stored: wr_idx wraps to 0, go to FILL_NEG.
- FILL_NEG:
  - Each in_valid computes mem[wr_idx] = {1'b0,pos} - {1'b0,data_in}, a (DW+1)-bit signed result with no overflow possible (range -255..+255 for DW=8).
  - After index N-1: go to DRAIN, set rd_idx=0.
- in_sop during FILL_POS or FILL_NEG (with in_valid): pulse frame_drop for 1 clk, discard the partial frame, and treat this sample as pos[0] of a new frame (state FILL_POS, wr_idx=1).
- DRAIN:
  - sink_valid rises at most 2 clk after the last negative sample is accepted.
  - sink_real = mem[rd_idx].
  - sink_sop = (rd_idx==0); sink_eop = (rd_idx==N-1).
  - Transfer occurs when sink_valid&&sink_ready; rd_idx then increments.
  - While sink_ready=0, sink_real, sink_sop and sink_eop hold stable.
  - After the eop transfer: sink_valid, sink_sop and sink_eop drop the next clk; go to IDLE.
  - in_valid&&in_sop in DRAIN: frame_drop pulses 1 clk, and that frame's samples are ignored until IDLE is re-entered.
- sink_valid is never asserted outside DRAIN.
- sink_sop/sink_eop are asserted only together with sink_valid.

Optional Feature:
- Macro: UOFDM_DEMAP_FRAME_CNT_EN.
- Defined: frame_cnt increments by 1 on each eop transfer; wraps 16'hFFFF -> 0; reset value 0.
- Undefined: frame_cnt is tied to 16'd0 and no counter logic is generated. All other behaviour is identical.

Test Plan:
- Basic frame: pos[k]=k+100, neg[k]=k, back-to-back in_valid, sink_ready=1.
  - Expect 128 outputs, all +100 (9'h064).
  - sink_sop on the first output only; sink_eop on the 128th only.
  - First sink_valid within 2 clk of the 256th input.
- Extremes: pos=255/neg=0 gives sink_real=9'h0FF; pos=0/neg=255 gives 9'h101 (-255); pos=neg=37 gives 0.
- Backpressure: sink_ready alternates 1,0 each clk.
  - All 128 values correct and in order.
  - Data/sop/eop stable on every ready=0 cycle.
  - Drain takes 256 clk.
- Resync: second in_sop at positive sample 50.
  - frame_drop is a single 1-clk pulse.
  - The following full frame (pos=200, neg=50) yields 128 outputs of +150 and no stale data.
- Frame during DRAIN: new in_sop with sink_ready=0.
  - frame_drop pulses once.
  - The current frame still drains correctly.
  - No output is produced for the rejected frame.
  - busy falls after the eop transfer.
- Reset mid-FILL_NEG (sample 60):
  - All outputs go to 0 asynchronously.
  - The next clean frame is correct.
  - With UOFDM_DEMAP_FRAME_CNT_EN, frame_cnt is 0 after reset and reads 3 after three completed frames; without the macro it stays 0.
